// File: rtl/design03_driver_if.sv
// design03_driver_if: method-port bundle between the sequencer and mkDesign_03.
//   start_a/start_b/EN_start/RDY_start : start(a,b) action method
//   result_c/result/RDY_result         : result(c) value method
//   check_d/EN_check/check/RDY_check   : check(d) actionvalue method
// Modports: master = sequencer side, slave = design side.
interface design03_driver_if #(
  parameter int W = 7
);
  logic [W-1:0] start_a;
  logic [W-1:0] start_b;
  logic         EN_start;
  logic         RDY_start;
  logic [W-1:0] result_c;
  logic [W-1:0] result;
  logic         RDY_result;
  logic [W-1:0] check_d;
  logic         EN_check;
  logic [W-1:0] check;
  logic         RDY_check;

  modport master (
    output start_a, start_b, EN_start, result_c, check_d, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check
  );

  modport slave (
    input  start_a, start_b, EN_start, result_c, check_d, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check
  );
endinterface

// File: rtl/design03_driver.sv
// design03_driver: upstream sequencer for mkDesign_03.
// On go it issues num_ops start(a,b) transactions, reads result(c) for each,
// calls check(d) with the captured result and counts mismatches.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   go, num_ops  run request and transaction count (sampled on accepted go)
//   bus          method-port bundle (master modport)
//   busy, done   run in progress / run finished (held until next go)
//   err_count    saturating mismatch count of the current run
//   last_result  most recently captured result
//   timeout      (DESIGN03_DRIVER_TIMEOUT_EN only) run aborted by watchdog
// Optional feature: define DESIGN03_DRIVER_TIMEOUT_EN to add a 1024-cycle
// no-progress watchdog and the timeout output.
module design03_driver #(
  parameter int W     = 7,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             go,
  input  logic [CNT_W-1:0] num_ops,
  design03_driver_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [W-1:0]     last_result
`ifdef DESIGN03_DRIVER_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Wide enough to hold idx*3 without truncation before the W-bit slice.
  localparam int XW = ((W > CNT_W) ? W : CNT_W) + 2;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [W-1:0]     cap_q, cap_d;
  logic [W-1:0]     last_q, last_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             en_start;
  logic             en_check;
  logic             go_acc;
  logic [XW-1:0]    idx_x;
  logic [XW-1:0]    idx_x3;
  logic [CNT_W:0]   idx_inc;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;

`ifdef DESIGN03_DRIVER_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'd1024;
  logic [15:0] wdog_q, wdog_d;
  logic        tmo_q, tmo_d;
  logic        fire;
`endif

  // Operands are a pure function of the transaction index.
  always_comb begin
    idx_x  = XW'(idx_q);
    idx_x3 = idx_x * XW'(3);
    op_a   = idx_x[W-1:0];
    op_b   = idx_x3[W-1:0];
  end

  // One extra bit so idx+1 == num_ops is exact even at num_ops = 2^CNT_W-1.
  assign idx_inc = {1'b0, idx_q} + (CNT_W+1)'(1);
  assign go_acc  = go && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    cap_d    = cap_q;
    last_d   = last_q;
    err_d    = err_q;
    en_start = 1'b0;
    en_check = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          num_d   = num_ops;
          idx_d   = '0;
          err_d   = '0;
          state_d = (num_ops == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Enable follows ready directly, so it can never lead it.
        if (bus.RDY_start) begin
          en_start = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.RDY_result) begin
          cap_d   = bus.result;
          last_d  = bus.result;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.RDY_check) begin
          en_check = 1'b1;
          if ((bus.check != cap_q) && (err_q != '1))
            err_d = err_q + CNT_W'(1);
          idx_d   = idx_inc[CNT_W-1:0];
          state_d = (idx_inc == {1'b0, num_q}) ? S_DONE : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DESIGN03_DRIVER_TIMEOUT_EN
    wdog_d = '0;
    tmo_d  = go_acc ? 1'b0 : tmo_q;
    if (busy && !fire) begin
      if (wdog_q == WDOG_LIMIT - 16'd1) begin
        // 1024th consecutive stall cycle: abandon the run.
        state_d = S_DONE;
        tmo_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end
`endif
  end

`ifdef DESIGN03_DRIVER_TIMEOUT_EN
  assign fire = en_start || en_check || ((state_q == S_WAIT) && bus.RDY_result);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

`ifdef DESIGN03_DRIVER_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
  assign timeout = tmo_q;
`endif

  assign bus.start_a  = op_a;
  assign bus.start_b  = op_b;
  assign bus.result_c = op_a ^ op_b;
  assign bus.EN_start = en_start;
  assign bus.check_d  = cap_q;
  assign bus.EN_check = en_check;

  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign err_count   = err_q;
  assign last_result = last_q;

endmodule

// File: tb/tb_design03_driver.sv
// Directed bench for design03_driver with a behavioural mkDesign_03 slave
// (result = a + b + c, check echoes d) and a start/check scoreboard.
module tb_design03_driver;
  localparam int W     = 7;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             go = 1'b0;
  logic [CNT_W-1:0] num_ops = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [W-1:0]     last_result;
`ifdef DESIGN03_DRIVER_TIMEOUT_EN
  logic             timeout;
`endif

  design03_driver_if #(.W(W)) bus ();

  always #5 CLK = ~CLK;

  design03_driver #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .go(go), .num_ops(num_ops), .bus(bus),
    .busy(busy), .done(done), .err_count(err_count), .last_result(last_result)
`ifdef DESIGN03_DRIVER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic         rdy_start_base = 1'b1;
  logic         rdy_result = 1'b1;
  logic         rdy_check = 1'b1;
  logic         stall_en = 1'b0;
  int           stall_cnt = 0;
  int           starts_seen = 0;
  int           checks_seen = 0;
  int           s0 = 0;
  int           c0 = 0;
  int           force_idx = -1;
  logic [W-1:0] sa = '0;
  logic [W-1:0] sbv = '0;
  logic [W-1:0] bump;
  logic         stall_now;

  // Stall window: after the first check of a run, before its second start.
  assign stall_now = stall_en && (starts_seen - s0 == 1) && (checks_seen - c0 == 1) && (stall_cnt < 5);
  always_comb bump = (force_idx >= 0 && (checks_seen - c0) == force_idx) ? W'(1) : '0;

  assign bus.RDY_start  = rdy_start_base && !stall_now;
  assign bus.RDY_result = rdy_result;
  assign bus.RDY_check  = rdy_check;
  assign bus.result     = sa + sbv + bus.result_c;
  assign bus.check      = bus.check_d + bump;

  always @(posedge CLK) begin
    if (bus.EN_start) begin
      sa          <= bus.start_a;
      sbv         <= bus.start_b;
      starts_seen <= starts_seen + 1;
    end
    if (bus.EN_check) checks_seen <= checks_seen + 1;
    if (stall_now) stall_cnt <= stall_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } exp_t;
  exp_t         sbq[$];
  logic [W-1:0] rq[$];

  function automatic logic [W-1:0] rexp(input int i);
    logic [W-1:0] a, b;
    a = W'(i);
    b = W'(3 * i);
    return a + b + (a ^ b);
  endfunction

  task automatic push_run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.a = W'(i);
      e.b = W'(3 * i);
      e.r = rexp(i);
      sbq.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (bus.EN_start) begin
        chk("start_needs_rdy", {31'd0, bus.RDY_start}, 32'd1);
        chk("one_fire", {31'd0, bus.EN_check}, 32'd0);
        if (sbq.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("start_a", {25'd0, bus.start_a}, {25'd0, e.a});
          chk("start_b", {25'd0, bus.start_b}, {25'd0, e.b});
          rq.push_back(e.r);
        end
      end
      if (bus.EN_check) begin
        chk("check_needs_rdy", {31'd0, bus.RDY_check}, 32'd1);
        if (rq.size() == 0) chk("check_unexpected", 32'd1, 32'd0);
        else chk("check_d", {25'd0, bus.check_d}, {25'd0, rq.pop_front()});
      end
    end
  end

  // Runs n transactions; returns busy cycle count. Optionally pulses a
  // stray go mid-run, which must be ignored.
  task automatic run(input int n, input bit stray_go, output int cyc);
    s0 = starts_seen;
    c0 = checks_seen;
    push_run(n);
    @(posedge CLK); #1;
    go = 1'b1;
    num_ops = CNT_W'(n);
    @(posedge CLK); #1;
    go = 1'b0;
    cyc = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (busy) cyc++;
      go = 1'b0;
      if (stray_go && k == 4) begin
        go = 1'b1;
        num_ops = CNT_W'(1);
      end
      @(posedge CLK); #1;
    end
    go = 1'b0;
    if (!done) chk("run_bound", 32'd0, 32'd1);
  endtask

  task automatic post_run(input string tag, input int n, input int cyc, input int exp_cyc,
                          input int exp_err);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_starts"}, starts_seen - s0, n);
    chk({tag, "_checks"}, checks_seen - c0, n);
    chk({tag, "_err"}, {24'd0, err_count}, exp_err);
    chk({tag, "_last"}, {25'd0, last_result}, {25'd0, rexp(n - 1)});
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, sbq.size() + rq.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_en_start", {31'd0, bus.EN_start}, 32'd0);
    chk("rst_en_check", {31'd0, bus.EN_check}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_last", {25'd0, last_result}, 32'd0);
    chk("rst_start_a", {25'd0, bus.start_a}, 32'd0);
    chk("rst_start_b", {25'd0, bus.start_b}, 32'd0);
    chk("rst_check_d", {25'd0, bus.check_d}, 32'd0);
    RST_N = 1'b1;

    // basic run, all ready
    run(4, 1'b0, cyc);
    post_run("basic", 4, cyc, 12, 0);

    // mismatch injected on idx 2
    force_idx = 2;
    run(4, 1'b0, cyc);
    force_idx = -1;
    post_run("mismatch", 4, cyc, 12, 1);

    // RDY_start low 5 cycles on the 2nd transaction
    stall_en = 1'b1;
    run(4, 1'b0, cyc);
    stall_en = 1'b0;
    post_run("stall", 4, cyc, 17, 0);
    chk("stall_len", stall_cnt, 5);

    // go while busy is ignored
    run(4, 1'b1, cyc);
    post_run("stray_go", 4, cyc, 12, 0);

    // num_ops = 0
    s0 = starts_seen;
    c0 = checks_seen;
    @(posedge CLK); #1;
    go = 1'b1;
    num_ops = '0;
    @(posedge CLK); #1;
    go = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("zero_no_fire", (starts_seen - s0) + (checks_seen - c0), 32'd0);
    chk("zero_still_done", {31'd0, done}, 32'd1);

    // maximum count, operand wrap
    run(255, 1'b0, cyc);
    post_run("max", 255, cyc, 765, 0);

    // reset while waiting for result
    rdy_result = 1'b0;
    s0 = starts_seen;
    c0 = checks_seen;
    push_run(4);
    @(posedge CLK); #1;
    go = 1'b1;
    num_ops = CNT_W'(4);
    @(posedge CLK); #1;
    go = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK); #1;
      seen = (starts_seen - s0 == 1);
    end
    chk("rst_mid_reached_wait", {31'd0, seen}, 32'd1);
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_mid_pre_busy", {31'd0, busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_en", {30'd0, bus.EN_start, bus.EN_check}, 32'd0);
    chk("rst_mid_start_a", {25'd0, bus.start_a}, 32'd0);
    sbq.delete();
    rq.delete();
    rdy_result = 1'b1;
    #2;
    RST_N = 1'b1;
    run(4, 1'b0, cyc);
    post_run("restart", 4, cyc, 12, 0);

`ifdef DESIGN03_DRIVER_TIMEOUT_EN
    rdy_result = 1'b0;
    run(1, 1'b0, cyc);
    chk("tmo_cycles", cyc, 1025);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    chk("tmo_done", {31'd0, done}, 32'd1);
    sbq.delete();
    rq.delete();
    rdy_result = 1'b1;
    run(1, 1'b0, cyc);
    chk("tmo_clear", {31'd0, timeout}, 32'd0);
    post_run("tmo_after", 1, cyc, 3, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
